// File: rtl/mvu_stream_sequencer.sv
// mvu_stream_sequencer: buffers one activation vector, replays it across all
// neuron folds, fetches folded weights and drives the MVU kernel; kernel
// results are queued in a small credit-protected output FIFO.
module mvu_stream_sequencer #(
  parameter int unsigned PE               = 2,
  parameter int unsigned SIMD             = 2,
  parameter int unsigned MW               = 4,
  parameter int unsigned MH               = 4,
  parameter int unsigned ACTIVATION_WIDTH = 8,
  parameter int unsigned WEIGHT_WIDTH     = 8,
  parameter int unsigned ACCU_WIDTH       = 24,
  parameter int unsigned OUT_DEPTH        = 4,
  parameter int unsigned KERNEL_LATENCY   = 5,
  localparam int unsigned SF    = MW / SIMD,
  localparam int unsigned NF    = MH / PE,
  localparam int unsigned ADDRW = (NF * SF > 1) ? $clog2(NF * SF) : 1,
  localparam int unsigned INW   = SIMD * ACTIVATION_WIDTH,
  localparam int unsigned WTW   = PE * SIMD * WEIGHT_WIDTH,
  localparam int unsigned PW    = PE * ACCU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INW-1:0]   in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic             wmem_rd,
  output logic [ADDRW-1:0] wmem_addr,
  input  logic [WTW-1:0]   wmem_rdata,
  output logic             k_en,
  output logic             k_last,
  output logic             k_zero,
  output logic [WTW-1:0]   k_w,
  output logic [INW-1:0]   k_a,
  input  logic             k_vld,
  input  logic [PW-1:0]    k_p,
  output logic [PW-1:0]    out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             busy
);

  localparam int unsigned SFW  = (SF > 1) ? $clog2(SF) : 1;
  localparam int unsigned NFW  = (NF > 1) ? $clog2(NF) : 1;
  localparam int unsigned CW   = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SUMW = CW + 1;
  localparam int unsigned PTRW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  // Reject parameter sets the sequencer cannot fold correctly
  if (OUT_DEPTH < 2 || KERNEL_LATENCY < 1 || (MW % SIMD) != 0 || (MH % PE) != 0) begin : g_param_check
    $error("mvu_stream_sequencer: illegal parameter set");
  end

  typedef enum logic [0:0] {FILL = 1'b0, REPLAY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SFW-1:0]   sf_q, sf_d;
  logic [NFW-1:0]   nf_q, nf_d;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]    fifo_mem [OUT_DEPTH];
  logic [INW-1:0]   abuf [SF];
  logic [INW-1:0]   act_sel;
  logic             credit_ok, last_beat, beat_ok, issue, push, pop;

  // Next-state, issue decision and fold counters
  always_comb begin
    state_d   = state_q;
    sf_d      = sf_q;
    nf_d      = nf_q;
    in_tready = 1'b0;
    issue     = 1'b0;
    act_sel   = abuf[sf_q];
    credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count_q}) < SUMW'(OUT_DEPTH);
    last_beat = (sf_q == SFW'(SF - 1));
    beat_ok   = !rst && (!last_beat || credit_ok);
    case (state_q)
      FILL: begin
        in_tready = beat_ok;
        issue     = beat_ok && in_tvalid;
        act_sel   = in_tdata;
      end
      REPLAY: issue = beat_ok;
      default: ;
    endcase
    if (issue) begin
      if (last_beat) begin
        sf_d = '0;
        if (nf_q == NFW'(NF - 1)) begin
          nf_d    = '0;
          state_d = FILL;
        end else begin
          nf_d    = nf_q + 1'b1;
          state_d = REPLAY;
        end
      end else begin
        sf_d = sf_q + 1'b1;
      end
    end
  end

  // State and fold counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      sf_q    <= '0;
      nf_q    <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= sf_d;
      nf_q    <= nf_d;
    end
  end

  // Capture the incoming vector for reuse by later folds
  always_ff @(posedge clk) begin
    if (issue && state_q == FILL) abuf[sf_q] <= in_tdata;
  end

  assign wmem_rd   = issue;
  assign wmem_addr = ADDRW'(nf_q) * ADDRW'(SF) + ADDRW'(sf_q);
  assign k_en      = !rst;
  assign k_w       = wmem_rdata;

  // Kernel input stage aligned with the one-cycle weight read
  always_ff @(posedge clk) begin
    if (rst) begin
      k_a    <= '0;
      k_last <= 1'b0;
      k_zero <= 1'b1;
    end else begin
      k_a    <= issue ? act_sel : '0;
      k_last <= issue && last_beat;
      k_zero <= !issue;
    end
  end

  // Results issued to the kernel but not yet returned
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else if ((issue && last_beat) && !k_vld) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (!(issue && last_beat) && k_vld) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  assign push = k_vld;
  assign pop  = out_tvalid && out_tready;

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Output FIFO occupancy
  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop)      fifo_count_d = fifo_count_q + 1'b1;
    else if (!push && pop) fifo_count_d = fifo_count_q - 1'b1;
  end

  // Output FIFO pointers and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_tvalid   <= 1'b0;
    end else begin
      fifo_count_q <= fifo_count_d;
      out_tvalid   <= (fifo_count_d != '0);
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
    end
  end

  // Output FIFO storage; a full FIFO may push only while popping the same slot
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= k_p;
  end

  assign out_tdata = fifo_mem[rd_ptr_q];
  assign busy      = (state_q == REPLAY) || (sf_q != '0) || (inflight_q != '0) || (fifo_count_q != '0);

endmodule
